// File: rtl/sram_sync.sv
// sram_sync: clocked behavioural model of an asynchronous-style static RAM.
// Active-low chip select / output enable / write enable, shared tri-state data bus.
// Reads are combinational from the array; writes commit on the rising clock edge.
// Optional feature macro: SRAM_CLEAR_ON_RESET_EN -- when defined, the array is swept
// to zero (one word per clock) after reset deasserts, before ready rises.
module sram_sync #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    inout  wire  [DATA_WIDTH-1:0] data,
    input  logic                  notOE,
    input  logic                  notWE,
    input  logic                  notCS,
    output logic                  ready
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [1:0] ST_IDLE  = 2'd0;
`ifdef SRAM_CLEAR_ON_RESET_EN
    localparam logic [1:0] ST_CLEAR = 2'd1;
`endif
    localparam logic [1:0] ST_READY = 2'd2;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [1:0]            r_state;
    logic [1:0]            w_state_d;
    logic                  r_ready;

    logic                  w_host_we;
    logic                  w_drive;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;
    logic [DATA_WIDTH-1:0] w_rdata;

`ifdef SRAM_CLEAR_ON_RESET_EN
    logic [ADDR_WIDTH-1:0] r_clr_addr;
`endif

    assign ready = r_ready;

    // Decode host strobes; X/Z on a control fails the equality test and reads as inactive.
    always_comb begin
        w_host_we = 1'b0;
        w_drive   = 1'b0;
        if (r_ready && (notCS == 1'b0) && (notWE == 1'b0)) begin
            w_host_we = 1'b1;
        end
        // Write has priority: never drive the bus while notWE is low.
        if (r_ready && (notCS == 1'b0) && (notOE == 1'b0) && (notWE == 1'b1)) begin
            w_drive = 1'b1;
        end
    end

    // Combinational read and tri-state bus driver.
    assign w_rdata = r_mem[addr];
    assign data    = w_drive ? w_rdata : {DATA_WIDTH{1'bz}};

    // Select the array write port: clear sweep during CLEAR, otherwise the host.
    always_comb begin
        w_mem_we    = w_host_we;
        w_mem_addr  = addr;
        w_mem_wdata = data;
`ifdef SRAM_CLEAR_ON_RESET_EN
        if (r_state == ST_CLEAR) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = r_clr_addr;
            w_mem_wdata = '0;
        end
`endif
    end

    // Array write; a reset edge suppresses any write at that edge.
    always_ff @(posedge clk) begin
        if (!reset && w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // Next-state logic for IDLE -> (CLEAR ->) READY.
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            ST_IDLE: begin
`ifdef SRAM_CLEAR_ON_RESET_EN
                w_state_d = ST_CLEAR;
`else
                w_state_d = ST_READY;
`endif
            end
`ifdef SRAM_CLEAR_ON_RESET_EN
            ST_CLEAR: begin
                if (r_clr_addr == {ADDR_WIDTH{1'b1}}) begin
                    w_state_d = ST_READY;
                end
            end
`endif
            ST_READY: w_state_d = ST_READY;
            default:  w_state_d = ST_IDLE;
        endcase
    end

    // State and registered ready; ready rises on the same edge that enters READY.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_ready <= (w_state_d == ST_READY);
        end
    end

`ifdef SRAM_CLEAR_ON_RESET_EN
    // Clear sweep address; restarts from 0 on any reset and wraps back to 0 after the last word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clr_addr <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_clr_addr <= r_clr_addr + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sram_sync.sv
// tb_sram_sync: randomized self-checking bench for sram_sync (DATA_WIDTH=4, ADDR_WIDTH=4).
// Reference model is a plain array with per-word "known" flags.
// Bus release is checked by driving 0 from the bench while the DUT should be off the bus;
// any DUT drive of a nonzero word shows up as a nonzero resolved value.
module tb_sram_sync;

    localparam int DW = 4;
    localparam int AW = 4;
    localparam int NW = 16;
`ifdef SRAM_CLEAR_ON_RESET_EN
    localparam int EXP_EDGES = NW + 1;
`else
    localparam int EXP_EDGES = 1;
`endif

    logic          clk;
    logic          reset;
    logic [AW-1:0] addr;
    wire  [DW-1:0] data;
    logic          notOE;
    logic          notWE;
    logic          notCS;
    logic          ready;

    logic [DW-1:0] tb_drv;
    logic          tb_en;
    assign data = tb_en ? tb_drv : {DW{1'bz}};

    logic [DW-1:0] model [NW];
    bit            known [NW];
    int            n_cmp;
    int            n_err;

    sram_sync #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .addr (addr),
        .data (data),
        .notOE(notOE),
        .notWE(notWE),
        .notCS(notCS),
        .ready(ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        notCS = 1'b1;
        notOE = 1'b1;
        notWE = 1'b1;
        tb_en = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        addr   = a;
        tb_drv = d;
        tb_en  = 1'b1;
        notOE  = 1'b1;
        notCS  = 1'b0;
        notWE  = 1'b0;
        tick();
        idle_bus();
        model[a] = d;
        known[a] = 1'b1;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input string tag);
        addr  = a;
        tb_en = 1'b0;
        notWE = 1'b1;
        notCS = 1'b0;
        notOE = 1'b0;
        #1;
        if (known[a]) check($sformatf("%s[%0d]", tag, a), {28'd0, data}, {28'd0, model[a]});
        idle_bus();
    endtask

    // Count edges from reset release until ready; writes to addr 0 are attempted meanwhile.
    task automatic release_and_wait(input string tag);
        int n;
        n      = 0;
        reset  = 1'b0;
        addr   = '0;
        tb_drv = 4'hF;
        tb_en  = 1'b1;
        notCS  = 1'b0;
        notWE  = 1'b0;
        notOE  = 1'b1;
        while (n < 100) begin
            tick();
            n++;
            if (ready === 1'b1) break;
        end
        idle_bus();
        check(tag, n, EXP_EDGES);
`ifdef SRAM_CLEAR_ON_RESET_EN
        for (int i = 0; i < NW; i++) begin
            model[i] = '0;
            known[i] = 1'b1;
        end
`endif
    endtask

    task automatic check_release(input logic cs, input logic oe, input logic we, input string tag);
        notCS  = cs;
        notOE  = oe;
        notWE  = we;
        tb_drv = '0;
        tb_en  = 1'b1;
        #1;
        check(tag, {28'd0, data}, 32'd0);
        idle_bus();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < NW; i++) begin
            model[i] = '0;
            known[i] = 1'b0;
        end
        idle_bus();
        addr   = '0;
        tb_drv = '0;
        reset  = 1'b1;
        tick();
        tick();
        check("reset_ready", {31'd0, ready}, 32'd0);
        release_and_wait("ready_edges_init");
        do_read(4'd0, "ignored_write_during_notready");

        // Write/read sweep.
        for (int i = 0; i < NW; i++) do_write(i[AW-1:0], i[DW-1:0]);
        for (int i = 0; i < NW; i++) do_read(i[AW-1:0], "sweep");

        // Bus release cases at addr 5 (holds 5).
        addr = 4'd5;
        check_release(1'b1, 1'b0, 1'b1, "release_cs_high");
        check_release(1'b0, 1'b1, 1'b1, "release_oe_high");
        check_release(1'b1, 1'b0, 1'b0, "release_cs_high_we_low");

        // Write with OE low: bench value seen on the bus without contention, then stored.
        addr   = 4'd9;
        tb_drv = 4'h5;
        tb_en  = 1'b1;
        notCS  = 1'b0;
        notOE  = 1'b0;
        notWE  = 1'b0;
        #1;
        check("write_no_contention", {28'd0, data}, 32'h5);
        tick();
        idle_bus();
        model[9] = 4'h5;
        do_read(4'd9, "write_with_oe");

        // Deselected write at addr 3.
        addr   = 4'd3;
        tb_drv = 4'hA;
        tb_en  = 1'b1;
        notCS  = 1'b1;
        notWE  = 1'b0;
        tick();
        tick();
        idle_bus();
        do_read(4'd3, "deselected_write");

        // Randomized traffic against the model.
        for (int k = 0; k < 200; k++) begin
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            a = AW'($urandom_range(0, NW - 1));
            d = DW'($urandom_range(0, NW - 1));
            case ($urandom_range(0, 3))
                0: do_write(a, d);
                1: do_read(a, "rand_read");
                2: begin
                    addr   = a;
                    tb_drv = d;
                    tb_en  = 1'b1;
                    notCS  = 1'b1;
                    notWE  = 1'b0;
                    tick();
                    idle_bus();
                end
                default: begin
                    addr = a;
                    if ($urandom_range(0, 1) == 0) check_release(1'b1, 1'b0, 1'b1, "rand_rel_cs");
                    else check_release(1'b0, 1'b1, 1'b1, "rand_rel_oe");
                end
            endcase
        end

        // Refill, then reset on the same edge as a write of C to addr 7.
        for (int i = 0; i < NW; i++) do_write(i[AW-1:0], i[DW-1:0]);
        tick();
        tick();
        addr   = 4'd7;
        tb_drv = 4'hC;
        tb_en  = 1'b1;
        notCS  = 1'b0;
        notWE  = 1'b0;
        reset  = 1'b1;
        tick();
        idle_bus();
        check("ready_in_reset", {31'd0, ready}, 32'd0);
        addr = 4'd7;
        check_release(1'b0, 1'b0, 1'b1, "release_not_ready");
        tick();
        release_and_wait("ready_edges_reset");
        for (int i = 0; i < NW; i++) do_read(i[AW-1:0], "after_reset");

        // Reset in the middle of the clear sweep (or shortly after release without it).
        for (int i = 0; i < NW; i++) do_write(i[AW-1:0], 4'hF - i[DW-1:0]);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        release_and_wait("ready_edges_midclear");
        for (int i = 0; i < NW; i++) do_read(i[AW-1:0], "after_midclear");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
